// File: rtl/mux_scan_pkg.sv
// Shared state encoding and helpers for the mux scan sequencer.
package mux_scan_pkg;

    localparam int DWELL_WIDTH_DEFAULT = 16;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_DWELL = 1'b1
    } scan_state_e;

    localparam logic [0:0] IDLE  = S_IDLE;
    localparam logic [0:0] DWELL = S_DWELL;

    // A dwell of zero behaves as one cycle so the channel counter always terminates.
    function automatic logic [31:0] dwell_min1(input logic [31:0] d);
        return (d == 32'd0) ? 32'd1 : d;
    endfunction

endpackage

// File: rtl/mux_scan_next_chan.sv
// Combinational channel search: next enabled index above cur, and lowest enabled index.
module mux_scan_next_chan #(
    parameter int N_INPUTS  = 3,
    parameter int SEL_WIDTH = 2
) (
    input  logic [N_INPUTS-1:0]  mask,
    input  logic [SEL_WIDTH-1:0] cur,
    output logic [SEL_WIDTH-1:0] next_idx,
    output logic                 has_next,
    output logic [SEL_WIDTH-1:0] low_idx
);

    // Descending scan: the last hit wins, leaving the lowest qualifying index.
    always_comb begin
        next_idx = '0;
        has_next = 1'b0;
        low_idx  = '0;
        for (int i = N_INPUTS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                low_idx = SEL_WIDTH'(i);
                if (i > int'(cur)) begin
                    next_idx = SEL_WIDTH'(i);
                    has_next = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps the latched mux select through enabled channels with a programmable dwell.
// Optional MUX_SCAN_SETTLE_EN adds a 'settle' input that extends valid blanking.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int N_INPUTS    = 3,
    parameter int SEL_WIDTH   = 2,
    parameter int DWELL_WIDTH = DWELL_WIDTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   continuous,
    input  logic [N_INPUTS-1:0]    chan_mask,
    input  logic [DWELL_WIDTH-1:0] dwell,
`ifdef MUX_SCAN_SETTLE_EN
    input  logic [DWELL_WIDTH-1:0] settle,
`endif
    output logic [SEL_WIDTH-1:0]   sel,
    output logic                   clken,
    output logic                   valid,
    output logic                   busy,
    output logic                   sweep_done
);

    logic [0:0]             state, state_n;
    logic [N_INPUTS-1:0]    mask_r, mask_n, mask_sel;
    logic [DWELL_WIDTH-1:0] dwell_r, dwell_n, cnt, cnt_n;
    logic [DWELL_WIDTH-1:0] settle_r, settle_n, settle_in;
    logic                   cont_r, cont_n;
    logic [SEL_WIDTH-1:0]   sel_n, next_idx, low_idx, high_idx;
    logic                   has_next, clken_n, valid_n, busy_n, sweep_done_n;
    logic [DWELL_WIDTH:0]   blank_end;

`ifdef MUX_SCAN_SETTLE_EN
    assign settle_in = settle;
`else
    assign settle_in = '0;
`endif

    // While idle the search looks at the live mask so the first channel is known at start.
    assign mask_sel = (state == IDLE) ? chan_mask : mask_r;

    mux_scan_next_chan #(
        .N_INPUTS (N_INPUTS),
        .SEL_WIDTH(SEL_WIDTH)
    ) u_next_chan (
        .mask    (mask_sel),
        .cur     (sel),
        .next_idx(next_idx),
        .has_next(has_next),
        .low_idx (low_idx)
    );

    always_comb begin
        state_n  = state;
        sel_n    = sel;
        cnt_n    = cnt;
        mask_n   = mask_r;
        dwell_n  = dwell_r;
        cont_n   = cont_r;
        settle_n = settle_r;
        clken_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop && (chan_mask != '0)) begin
                    state_n  = DWELL;
                    mask_n   = chan_mask;
                    dwell_n  = DWELL_WIDTH'(dwell_min1(32'(dwell)));
                    cont_n   = continuous;
                    settle_n = settle_in;
                    sel_n    = low_idx;
                    cnt_n    = DWELL_WIDTH'(1);
                    clken_n  = 1'b1;
                end
            end
            DWELL: begin
                if (stop) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == dwell_r) begin
                    if (has_next) begin
                        sel_n   = next_idx;
                        cnt_n   = DWELL_WIDTH'(1);
                        clken_n = 1'b1;
                    end else if (cont_r) begin
                        sel_n   = low_idx;
                        cnt_n   = DWELL_WIDTH'(1);
                        clken_n = 1'b1;
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end else begin
                    cnt_n = cnt + DWELL_WIDTH'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Registered outputs are derived from the next state, so sweep_done needs the top channel ahead of time.
    always_comb begin
        high_idx = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (mask_n[i]) high_idx = SEL_WIDTH'(i);
        end
        blank_end    = {1'b0, settle_n} + (DWELL_WIDTH+1)'(1);
        busy_n       = (state_n == DWELL);
        valid_n      = busy_n && !clken_n && ({1'b0, cnt_n} > blank_end);
        sweep_done_n = busy_n && (cnt_n == dwell_n) && (sel_n == high_idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sel        <= '0;
            cnt        <= '0;
            mask_r     <= '0;
            dwell_r    <= '0;
            cont_r     <= 1'b0;
            settle_r   <= '0;
            clken      <= 1'b0;
            valid      <= 1'b0;
            busy       <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            state      <= state_n;
            sel        <= sel_n;
            cnt        <= cnt_n;
            mask_r     <= mask_n;
            dwell_r    <= dwell_n;
            cont_r     <= cont_n;
            settle_r   <= settle_n;
            clken      <= clken_n;
            valid      <= valid_n;
            busy       <= busy_n;
            sweep_done <= sweep_done_n;
        end
    end

endmodule
